// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
//   Shared types for the retired-store buffer: address type, buffer entry
//   layout, drain FSM state encoding and the 8-byte block match helper.
package store_buffer_pkg;

  typedef logic [31:0] PC_t;

  localparam int SB_DEPTH_DEFAULT = 4;

  // Stores are tracked at 8-byte block granularity; low three address bits
  // never take part in a forwarding match.
  localparam PC_t BLK_MASK = 32'hFFFF_FFF8;

  typedef struct packed {
    PC_t         addr;
    logic [63:0] data;
    logic        valid;
  } SB_ENTRY;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_ISSUE = 2'd1,
    SB_GAP   = 2'd2
  } sb_state_e;

  function automatic logic blk_match(input PC_t a, input PC_t b);
    return ((a ^ b) & BLK_MASK) == '0;
  endfunction

endpackage

// File: rtl/store_buffer_fwd.sv
// store_buffer_fwd
//   Youngest-match selector for one load port. Walks the buffer from the
//   slot just behind tail towards older entries and returns the first valid
//   entry whose 8-byte block matches the probe address.
// Ports:
//   entries   - all buffer slots (addr, data, valid)
//   tail      - next write slot; tail-1 is the youngest entry
//   load_addr - probe address of this load port
//   hit       - some valid entry matches
//   data      - data of the youngest match, 0 when no match
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(SB_DEPTH)
) (
  input  SB_ENTRY [SB_DEPTH-1:0] entries,
  input  logic    [PTR_W-1:0]    tail,
  input  PC_t                    load_addr,
  output logic                   hit,
  output logic    [63:0]         data
);

  logic [PTR_W-1:0] idx;

  // k = SB_DEPTH wraps back onto tail itself, which is the oldest slot
  // when the buffer is full.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 1; k <= SB_DEPTH; k++) begin
      idx = tail - PTR_W'(k);
      if (!hit && entries[idx].valid && blk_match(entries[idx].addr, load_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
//   Circular FIFO of retired stores drained one at a time into the dcache,
//   with store-to-load forwarding for two load ports.
//
//   state | meaning
//   IDLE  | no request to dcache; move to ISSUE when entries are buffered
//   ISSUE | head entry presented on store_*; leave on accept or flush
//   GAP   | one dead cycle so the next store looks like a fresh request
//
// Ports:
//   clock, reset        - sole clock; synchronous active-low reset
//   enq_valid/addr/data - retired store to buffer; enq_ready = not full
//   flush               - pipeline flush; cancels the store in flight only
//   load_addr, fwd_*    - per-load-port forwarding probe and result
//   store_en/addr/data  - request to dcache; store_accepted is its ack
//   count               - number of buffered entries
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enq_valid,
  input  PC_t                       enq_addr,
  input  logic [63:0]               enq_data,
  output logic                      enq_ready,
  input  logic                      flush,
  input  logic [1:0][31:0]          load_addr,
  output logic [1:0]                fwd_hit,
  output logic [1:0][63:0]          fwd_data,
  output logic                      store_en,
  output logic [31:0]               store_addr,
  output logic [63:0]               store_data,
  input  logic                      store_accepted,
  output logic [$clog2(SB_DEPTH):0] count
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  SB_ENTRY [SB_DEPTH-1:0] entries;
  logic    [PTR_W-1:0]    head;
  logic    [PTR_W-1:0]    tail;
  logic    [CNT_W-1:0]    cnt;
  sb_state_e              state;

  logic       not_full;
  logic       do_enq;
  logic       do_deq;
  logic [1:0] raw_hit;
  logic [1:0][63:0] raw_data;

  assign not_full = cnt < CNT_W'(SB_DEPTH);
  assign do_enq   = enq_valid && not_full;
  // A flush in the same cycle means the dcache dropped this store.
  assign do_deq   = (state == SB_ISSUE) && store_accepted && !flush;

  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      state <= SB_IDLE;
      for (int i = 0; i < SB_DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      if (do_enq) begin
        entries[tail] <= '{addr: enq_addr, data: enq_data, valid: 1'b1};
        tail          <= tail + PTR_W'(1);
      end
      if (do_deq) begin
        entries[head].valid <= 1'b0;
        head                <= head + PTR_W'(1);
      end
      case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      case (state)
        SB_IDLE:  if (cnt != '0) state <= SB_ISSUE;
        SB_ISSUE: if (flush || store_accepted) state <= SB_GAP;
        SB_GAP:   state <= SB_IDLE;
        default:  state <= SB_IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_fwd
    store_buffer_fwd #(.SB_DEPTH(SB_DEPTH)) u_fwd (
      .entries   (entries),
      .tail      (tail),
      .load_addr (load_addr[p]),
      .hit       (raw_hit[p]),
      .data      (raw_data[p])
    );
  end

  // Outputs are forced to their reset values while reset is asserted so the
  // dcache and load ports see a quiet buffer before the first clock edge.
  always_comb begin
    store_en   = reset && (state == SB_ISSUE);
    store_addr = store_en ? entries[head].addr : '0;
    store_data = store_en ? entries[head].data : '0;
    enq_ready  = !reset || not_full;
    count      = reset ? cnt : '0;
    fwd_hit    = reset ? raw_hit : '0;
    fwd_data   = reset ? raw_data : '0;
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enq_valid = 1'b0;
  logic [31:0]      enq_addr = '0;
  logic [63:0]      enq_data = '0;
  logic             flush = 1'b0;
  logic [1:0][31:0] load_addr = '0;
  logic             store_accepted = 1'b0;
  logic             enq_ready;
  logic [1:0]       fwd_hit;
  logic [1:0][63:0] fwd_data;
  logic             store_en;
  logic [31:0]      store_addr;
  logic [63:0]      store_data;
  logic [2:0]       count;

  store_buffer #(.SB_DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .enq_valid      (enq_valid),
    .enq_addr       (enq_addr),
    .enq_data       (enq_data),
    .enq_ready      (enq_ready),
    .flush          (flush),
    .load_addr      (load_addr),
    .fwd_hit        (fwd_hit),
    .fwd_data       (fwd_data),
    .store_en       (store_en),
    .store_addr     (store_addr),
    .store_data     (store_data),
    .store_accepted (store_accepted),
    .count          (count)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of buffered stores plus the drain
  // timing rule "after a store leaves ISSUE, one dead cycle, then one
  // decision cycle before the next issue".
  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
  } ment_t;

  ment_t mq[$];
  bit    m_issuing = 1'b0;
  bit    m_cool = 1'b0;

  always @(posedge clock) begin
    int pre;
    bit deq;
    ment_t e;
    pre = mq.size();
    deq = 1'b0;
    if (!reset) begin
      mq.delete();
      m_issuing = 1'b0;
      m_cool    = 1'b0;
    end else begin
      if (m_issuing) begin
        if (flush || store_accepted) begin
          deq       = !flush;
          m_issuing = 1'b0;
          m_cool    = 1'b1;
        end
      end else if (m_cool) begin
        m_cool = 1'b0;
      end else if (pre != 0) begin
        m_issuing = 1'b1;
      end
      if (deq) void'(mq.pop_front());
      if (enq_valid && pre < DEPTH) begin
        e.a = enq_addr;
        e.d = enq_data;
        mq.push_back(e);
      end
    end
  end

  function automatic void model_fwd(input logic [31:0] la, output logic h, output logic [63:0] d);
    h = 1'b0;
    d = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a[31:3] == la[31:3]) begin
        h = 1'b1;
        d = mq[i].d;
        break;
      end
    end
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    logic        e_h;
    logic [63:0] e_d;
    if (!reset) begin
      check("count", 64'(count), 64'd0);
      check("enq_ready", 64'(enq_ready), 64'd1);
      check("store_en", 64'(store_en), 64'd0);
      check("store_addr", 64'(store_addr), 64'd0);
      check("store_data", store_data, 64'd0);
      check("fwd_hit", 64'(fwd_hit), 64'd0);
      check("fwd_data0", fwd_data[0], 64'd0);
      check("fwd_data1", fwd_data[1], 64'd0);
    end else begin
      check("count", 64'(count), 64'(mq.size()));
      check("enq_ready", 64'(enq_ready), 64'(mq.size() < DEPTH));
      check("store_en", 64'(store_en), 64'(m_issuing));
      check("store_addr", 64'(store_addr), m_issuing ? 64'(mq[0].a) : 64'd0);
      check("store_data", store_data, m_issuing ? mq[0].d : 64'd0);
      for (int p = 0; p < 2; p++) begin
        model_fwd(load_addr[p], e_h, e_d);
        check("fwd_hit_p", 64'(fwd_hit[p]), 64'(e_h));
        check("fwd_data_p", fwd_data[p], e_d);
      end
    end
  end

  // Records stores actually handed to the dcache during the wrap test.
  bit          collect = 1'b0;
  logic [31:0] got[$];
  always @(negedge clock) begin
    if (collect && reset && store_en && store_accepted && !flush) got.push_back(store_addr);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic at_mid();
    @(negedge clock);
  endtask

  task automatic enq(input logic [31:0] a, input logic [63:0] d);
    enq_valid = 1'b1;
    enq_addr  = a;
    enq_data  = d;
    cyc();
    enq_valid = 1'b0;
  endtask

  task automatic drain();
    store_accepted = 1'b1;
    for (int k = 0; k < 100 && count != 0; k++) cyc();
    if (count != 0) check("drain_timeout", 64'(count), 64'd0);
    store_accepted = 1'b0;
    cyc();
    cyc();
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'h4000 + 32'($urandom_range(0, 7) << 3) + 32'($urandom_range(0, 7));
  endfunction

  initial begin
    repeat (3) cyc();
    at_mid();
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(enq_ready), 64'd1);
    check("rst_store_en", 64'(store_en), 64'd0);
    cyc();
    reset = 1'b1;

    // Basic drain timing
    enq(32'h100, 64'hAA);
    at_mid();
    check("drain_c1_count", 64'(count), 64'd1);
    check("drain_c1_en", 64'(store_en), 64'd0);
    cyc();
    at_mid();
    check("drain_c2_en", 64'(store_en), 64'd1);
    check("drain_c2_addr", 64'(store_addr), 64'h100);
    check("drain_c2_data", store_data, 64'hAA);
    cyc();
    cyc();
    store_accepted = 1'b1;
    at_mid();
    check("drain_c4_en", 64'(store_en), 64'd1);
    cyc();
    store_accepted = 1'b0;
    at_mid();
    check("drain_c5_count", 64'(count), 64'd0);
    check("drain_c5_en", 64'(store_en), 64'd0);
    cyc();
    cyc();

    // Full buffer
    for (int i = 0; i < 4; i++) enq(32'h500 + 32'(i * 8), 64'(i + 1));
    enq_valid = 1'b1;
    enq_addr  = 32'h5F0;
    enq_data  = 64'hDEAD;
    at_mid();
    check("full_ready", 64'(enq_ready), 64'd0);
    check("full_count", 64'(count), 64'd4);
    cyc();
    enq_valid = 1'b0;
    store_accepted = 1'b1;
    at_mid();
    check("full_5th_ignored", 64'(count), 64'd4);
    check("full_issue_addr", 64'(store_addr), 64'h500);
    check("full_ready_same_cycle", 64'(enq_ready), 64'd0);
    cyc();
    store_accepted = 1'b0;
    at_mid();
    check("full_after_accept_count", 64'(count), 64'd3);
    check("full_after_accept_ready", 64'(enq_ready), 64'd1);
    drain();

    // Forwarding, youngest match wins
    enq(32'h200, 64'h11);
    enq(32'h204, 64'h22);
    load_addr[0] = 32'h200;
    load_addr[1] = 32'h204;
    at_mid();
    check("fwd0_hit", 64'(fwd_hit[0]), 64'd1);
    check("fwd0_data", fwd_data[0], 64'h22);
    check("fwd1_data", fwd_data[1], 64'h22);
    cyc();
    load_addr[0] = 32'h208;
    at_mid();
    check("fwd0_miss_hit", 64'(fwd_hit[0]), 64'd0);
    check("fwd0_miss_data", fwd_data[0], 64'd0);
    load_addr = '0;
    drain();

    // Flush overrides acceptance
    enq(32'h300, 64'h33);
    for (int k = 0; k < 10 && !store_en; k++) cyc();
    check("flush_reached_issue", 64'(store_en), 64'd1);
    flush = 1'b1;
    store_accepted = 1'b1;
    cyc();
    flush = 1'b0;
    store_accepted = 1'b0;
    at_mid();
    check("flush_count_kept", 64'(count), 64'd1);
    check("flush_gap_en", 64'(store_en), 64'd0);
    cyc();
    at_mid();
    check("flush_idle_en", 64'(store_en), 64'd0);
    cyc();
    at_mid();
    check("flush_reissue_en", 64'(store_en), 64'd1);
    check("flush_reissue_addr", 64'(store_addr), 64'h300);
    drain();

    // Wrap-around ordering
    got.delete();
    collect = 1'b1;
    store_accepted = 1'b1;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 50 && !enq_ready; k++) cyc();
      enq(32'h1000 + 32'(i * 8), 64'(i));
    end
    drain();
    collect = 1'b0;
    check("wrap_count", 64'(got.size()), 64'd10);
    for (int i = 0; i < got.size() && i < 10; i++) check("wrap_addr", 64'(got[i]), 64'h1000 + 64'(i * 8));

    // Reset mid-ISSUE
    enq(32'h700, 64'h70);
    enq(32'h708, 64'h71);
    enq(32'h710, 64'h72);
    load_addr[0] = 32'h700;
    at_mid();
    check("rmid_count", 64'(count), 64'd3);
    check("rmid_en", 64'(store_en), 64'd1);
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    at_mid();
    check("rmid_after_count", 64'(count), 64'd0);
    check("rmid_after_en", 64'(store_en), 64'd0);
    check("rmid_after_hit", 64'(fwd_hit), 64'd0);
    load_addr = '0;
    cyc();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 299) != 0);
      enq_valid      = $urandom_range(0, 1) == 1;
      enq_addr       = rnd_addr();
      enq_data       = {$urandom(), $urandom()};
      flush          = $urandom_range(0, 9) == 0;
      store_accepted = $urandom_range(0, 4) < 2;
      load_addr[0]   = rnd_addr();
      load_addr[1]   = rnd_addr();
      cyc();
    end
    reset = 1'b1;
    enq_valid = 1'b0;
    flush = 1'b0;
    store_accepted = 1'b0;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
